// File: rtl/mips_pkg.sv
// mips_pkg: shared register-file constants and address type
package mips_pkg;
  localparam int REG_ZERO = 0;
  localparam int SEED_R1 = 1;
  localparam int SEED_R2 = 2;
  localparam int REG_AW = 4;
  typedef logic [REG_AW-1:0] reg_addr_t;
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register busy bits with issue/writeback priority and hazard lookups
// Ports: clk, rst (sync, active-high); ra_addr/rb_addr -> ra_busy/rb_busy;
// wr_en/wr_addr clear busy; iss_en/iss_addr set busy; iss_ready = target free after write.
// Macro REGFILE_BYPASS_EN: read-port busy lookups also see the same-cycle write clear.
module reg_scoreboard
  import mips_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra_addr,
  input  logic [AW-1:0] rb_addr,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic          iss_en,
  input  logic [AW-1:0] iss_addr,
  output logic          ra_busy,
  output logic          rb_busy,
  output logic          iss_ready
);
  logic [DEPTH-1:0] busy, clr, set, post;
  // post is the busy view after this cycle's writeback; issue is judged against it
  // so a write and re-issue to the same register in one cycle lands busy (new producer wins)
  always_comb begin
    clr = (wr_en && wr_addr != AW'(REG_ZERO)) ? DEPTH'(1) << wr_addr : '0;
    post = busy & ~clr;
    iss_ready = ~post[iss_addr];
    set = (iss_en && iss_ready && iss_addr != AW'(REG_ZERO)) ? DEPTH'(1) << iss_addr : '0;
  end
  always_ff @(posedge clk)
    busy <= rst ? '0 : post | set;
`ifdef REGFILE_BYPASS_EN
  assign ra_busy = post[ra_addr];
  assign rb_busy = post[rb_addr];
`else
  assign ra_busy = busy[ra_addr];
  assign rb_busy = busy[rb_addr];
`endif
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: 2R1W register file (r0 = 0) with per-register scoreboard for RAW hazards
// Ports: clk, rst (sync, active-high); ra_addr/rb_addr -> ra_data/rb_data, ra_busy/rb_busy, hazard;
// wr_en/wr_addr/wr_data writeback; iss_en/iss_addr issue, iss_ready accept.
// Macro REGFILE_BYPASS_EN: same-cycle writeback forwarded to read ports.
module reg_file_sb
  import mips_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    ra_addr,
  input  logic [AW-1:0]    rb_addr,
  output logic [WIDTH-1:0] ra_data,
  output logic [WIDTH-1:0] rb_data,
  output logic             ra_busy,
  output logic             rb_busy,
  output logic             hazard,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_addr,
  output logic             iss_ready
);
  logic [WIDTH-1:0] regs [DEPTH];
  // r1/r2 come up holding seeded memory pointers
  always_ff @(posedge clk)
    if (rst)
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= i == 1 ? WIDTH'(SEED_R1) : i == 2 ? WIDTH'(SEED_R2) : '0;
    else if (wr_en && wr_addr != AW'(REG_ZERO))
      regs[wr_addr] <= wr_data;
`ifdef REGFILE_BYPASS_EN
  assign ra_data = ra_addr == AW'(REG_ZERO) ? '0 : (wr_en && wr_addr == ra_addr) ? wr_data : regs[ra_addr];
  assign rb_data = rb_addr == AW'(REG_ZERO) ? '0 : (wr_en && wr_addr == rb_addr) ? wr_data : regs[rb_addr];
`else
  assign ra_data = ra_addr == AW'(REG_ZERO) ? '0 : regs[ra_addr];
  assign rb_data = rb_addr == AW'(REG_ZERO) ? '0 : regs[rb_addr];
`endif
  assign hazard = ra_busy | rb_busy;
  reg_scoreboard #(.DEPTH(DEPTH), .AW(AW)) u_sb (
    .clk(clk),
    .rst(rst),
    .ra_addr(ra_addr),
    .rb_addr(rb_addr),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .iss_en(iss_en),
    .iss_addr(iss_addr),
    .ra_busy(ra_busy),
    .rb_busy(rb_busy),
    .iss_ready(iss_ready)
  );
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed scoreboard-driven checks of reg_file_sb
module tb_reg_file_sb;
  import mips_pkg::*;
  logic clk = 0, rst = 1;
  reg_addr_t ra_addr = '0, rb_addr = '0, wr_addr = '0, iss_addr = '0;
  logic [15:0] ra_data, rb_data, wr_data = '0;
  logic ra_busy, rb_busy, hazard, wr_en = 0, iss_en = 0, iss_ready;
  logic [15:0] exp_q [$];
  int n_chk = 0, n_pass = 0;
  reg_file_sb dut (
    .clk(clk), .rst(rst), .ra_addr(ra_addr), .rb_addr(rb_addr),
    .ra_data(ra_data), .rb_data(rb_data), .ra_busy(ra_busy), .rb_busy(rb_busy),
    .hazard(hazard), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_ready(iss_ready)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic exp(input logic [15:0] v);
    exp_q.push_back(v);
  endtask
  task automatic check(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    n_chk++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s: observed %h with no expected value queued", tag, obs);
      return;
    end
    e = exp_q.pop_front();
    assert (obs === e) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, e);
  endtask
  initial begin
    tick;
    tick;
    rst = 0;
    ra_addr = 1; rb_addr = 2;
    exp(16'd1); exp(16'd2); exp(16'd0);
    #1;
    check("reset_r1", ra_data);
    check("reset_r2", rb_data);
    check("reset_hazard", 16'(hazard));
    ra_addr = 5;
    exp(16'd0); exp(16'd0);
    #1;
    check("reset_r5", ra_data);
    check("reset_r5_busy", 16'(ra_busy));
    tick;
    wr_en = 1; wr_addr = 0; wr_data = 16'hBEEF;
    tick;
    wr_en = 0; ra_addr = 0;
    exp(16'd0);
    #1;
    check("r0_read", ra_data);
    iss_en = 1; iss_addr = 0;
    exp(16'd1);
    #1;
    check("r0_iss_ready", 16'(iss_ready));
    tick;
    iss_en = 0;
    exp(16'd0);
    #1;
    check("r0_busy", 16'(ra_busy));
    iss_en = 1; iss_addr = 3; ra_addr = 3;
    exp(16'd1); exp(16'd0);
    #1;
    check("r3_iss_ready", 16'(iss_ready));
    check("r3_busy_pre", 16'(ra_busy));
    tick;
    exp(16'd1); exp(16'd1); exp(16'd0);
    #1;
    check("r3_busy", 16'(ra_busy));
    check("r3_hazard", 16'(hazard));
    check("r3_reissue_ready", 16'(iss_ready));
    tick;
    iss_en = 0;
    exp(16'd1);
    #1;
    check("r3_busy_held", 16'(ra_busy));
    wr_en = 1; wr_addr = 3; wr_data = 16'h1234;
`ifdef REGFILE_BYPASS_EN
    exp(16'h1234); exp(16'd0);
`else
    exp(16'd0); exp(16'd1);
`endif
    #1;
    check("r3_wr_data_same", ra_data);
    check("r3_wr_busy_same", 16'(ra_busy));
    tick;
    wr_en = 0;
    exp(16'h1234); exp(16'd0); exp(16'd0);
    #1;
    check("r3_data", ra_data);
    check("r3_busy_clr", 16'(ra_busy));
    check("r3_hazard_clr", 16'(hazard));
    rb_addr = 4;
    wr_en = 1; wr_addr = 4; wr_data = 16'h00AA;
`ifdef REGFILE_BYPASS_EN
    exp(16'h00AA);
`else
    exp(16'd0);
`endif
    exp(16'd0);
    #1;
    check("r4_data_same", rb_data);
    check("r4_busy_same", 16'(rb_busy));
    tick;
    wr_en = 0;
    exp(16'h00AA); exp(16'd0);
    #1;
    check("r4_data", rb_data);
    check("r4_busy", 16'(rb_busy));
    iss_en = 1; iss_addr = 6; ra_addr = 6;
    tick;
    wr_en = 1; wr_addr = 6; wr_data = 16'h5555;
    exp(16'd1);
    #1;
    check("r6_iss_ready", 16'(iss_ready));
    tick;
    wr_en = 0; iss_en = 0;
    exp(16'h5555); exp(16'd1);
    #1;
    check("r6_data", ra_data);
    check("r6_busy", 16'(ra_busy));
    wr_en = 1; wr_addr = 3; wr_data = 16'h4321;
    iss_en = 1; iss_addr = 5;
    tick;
    wr_en = 0; iss_en = 0; ra_addr = 3; rb_addr = 5;
    exp(16'h4321); exp(16'd0); exp(16'd1);
    #1;
    check("diff_r3_data", ra_data);
    check("diff_r3_busy", 16'(ra_busy));
    check("diff_r5_busy", 16'(rb_busy));
    iss_en = 1; iss_addr = 7;
    wr_en = 1; wr_addr = 9; wr_data = 16'h7777;
    tick;
    iss_en = 0; wr_en = 0; ra_addr = 7; rb_addr = 9;
    exp(16'd1); exp(16'h7777);
    #1;
    check("pre_rst_r7_busy", 16'(ra_busy));
    check("pre_rst_r9_data", rb_data);
    rst = 1;
    tick;
    rst = 0;
    exp(16'd0); exp(16'd0);
    #1;
    check("rst_r7_busy", 16'(ra_busy));
    check("rst_r9_data", rb_data);
    ra_addr = 1; rb_addr = 5;
    exp(16'd1); exp(16'd0); exp(16'd0);
    #1;
    check("rst_r1_data", ra_data);
    check("rst_r5_busy", 16'(rb_busy));
    check("rst_hazard", 16'(hazard));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
